// File: rtl/mc_control_fsm_pkg.sv
// mc_control_fsm_pkg: shared state, opcode, funct and datapath-select codes for the multicycle controller
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic op_legal(input logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_RTYPE ||
               op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// mc_control_fsm_alu_decoder: maps ALUOp and funct to the 3-bit ALU control code
module mc_control_fsm_alu_decoder
    import mc_control_fsm_pkg::*;
#(
    parameter int FNW = 6
) (
    input  logic [1:0]     alu_op,
    input  logic [FNW-1:0] funct,
    output logic [2:0]     alu_control
);

    logic [2:0] fn_ctl;

    always_comb begin
        fn_ctl = funct == FN_ADD ? ALU_ADD :
                 funct == FN_SUB ? ALU_SUB :
                 funct == FN_AND ? ALU_AND :
                 funct == FN_OR  ? ALU_OR  :
                 funct == FN_SLT ? ALU_SLT : ALU_ADD;
        alu_control = alu_op == ALUOP_SUB ? ALU_SUB :
                      alu_op == ALUOP_FN  ? fn_ctl  : ALU_ADD;
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore controller sequencing the multicycle datapath through fetch/decode/execute/writeback
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [OPW-1:0]     Op,
    input  logic [FNW-1:0]     Funct,
    input  logic               Zero,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_t     state, state_next;
    logic [1:0] alu_op;
    logic       pc_write, branch, ir_write, mem_write, reg_write;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = (Op == OP_LW || Op == OP_SW) ? S_MEMADR  :
                                    Op == OP_RTYPE               ? S_RTYPEEX :
                                    Op == OP_BEQ                 ? S_BEQEX   :
                                    Op == OP_ADDI                ? S_ADDIEX  :
                                    Op == OP_J                   ? S_JEX     : S_FETCH;
            S_MEMADR:  state_next = Op == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        PCSrc     = PC_ALU;
        Illegal   = 1'b0;
        alu_op    = ALUOP_ADD;
        pc_write  = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        case (state)
            S_FETCH:   begin ir_write = 1'b1; ALUSrcB = SRCB_4; pc_write = 1'b1; end
            S_DECODE:  begin ALUSrcB = SRCB_BR; Illegal = ~op_legal(Op); end
            S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
            S_MEMRD:   IorD = 1'b1;
            S_MEMWB:   begin reg_write = 1'b1; MemtoReg = 1'b1; end
            S_MEMWR:   begin IorD = 1'b1; mem_write = 1'b1; end
            S_RTYPEEX: begin ALUSrcA = 1'b1; alu_op = ALUOP_FN; end
            S_ALUWB:   begin RegDst = 1'b1; reg_write = 1'b1; end
            S_BEQEX:   begin ALUSrcA = 1'b1; alu_op = ALUOP_SUB; PCSrc = PC_ALUOUT; branch = 1'b1; end
            S_ADDIEX:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
            S_ADDIWB:  reg_write = 1'b1;
            S_JEX:     begin PCSrc = PC_JUMP; pc_write = 1'b1; end
            default:   ;
        endcase
    end

    // Write enables are gated by RESET so nothing commits while the FSM is held in FETCH
    assign PCEn     = ~RESET & (pc_write | (branch & Zero));
    assign IRWrite  = ~RESET & ir_write;
    assign MemWrite = ~RESET & mem_write;
    assign RegWrite = ~RESET & reg_write;
    assign State    = STATE_W'(state);

    mc_control_fsm_alu_decoder #(.FNW(FNW)) u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven instruction checks, reset corner case and randomized instruction stream vs reference model
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int n_cmp = 0;
    int n_bad = 0;

    mc_control_fsm dut (
        .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .State(State)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
        int         rw;
        int         mw;
        int         pe;
        int         il;
        logic [2:0] a3;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             output int lat, output int rw, output int mw, output int pe,
                             output int il, output logic [2:0] a3);
        lat = 0; rw = 0; mw = 0; pe = 0; il = 0; a3 = '0;
        Op = op; Funct = fn; Zero = z;
        do begin
            #1;
            if (lat == 2) a3 = ALUControl;
            rw += int'(RegWrite);
            mw += int'(MemWrite);
            pe += int'(PCEn);
            il += int'(Illegal);
            lat++;
            tick;
        end while (State != 4'd0 && lat < 12);
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Instruction-level model: the list of states an opcode walks through
    function automatic void seq_of(input logic [5:0] op, output int q[$]);
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            default:   q = '{0, 1};
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [16:0] ref_out(input int st, input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic iord = 0, memw = 0, irw = 0, regdst = 0, m2r = 0, regw = 0, srca = 0, pcen = 0, ill = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic [2:0] aluc = 3'b010;
        case (st)
            0:  begin irw = 1; srcb = 2'b01; pcen = 1; end
            1:  begin srcb = 2'b11; ill = !legal(op); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin regw = 1; m2r = 1; end
            5:  begin iord = 1; memw = 1; end
            6:  begin srca = 1; aluc = rtype_alu(fn); end
            7:  begin regdst = 1; regw = 1; end
            8:  begin srca = 1; aluc = 3'b110; pcsrc = 2'b01; pcen = z; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: regw = 1;
            11: begin pcsrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {iord, memw, irw, regdst, m2r, regw, srca, srcb, aluc, pcsrc, pcen, ill};
    endfunction

    function automatic logic [16:0] dut_out();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                ALUControl, PCSrc, PCEn, Illegal};
    endfunction

    initial begin
        int lat, rw, mw, pe, il;
        logic [2:0] a3;
        int q[$];
        logic [5:0] op, fn;
        logic [5:0] fns[6];

        vt[0]  = '{"lw",      6'b100011, 6'b000000, 1'b0, 5, 1, 0, 1, 0, 3'b010};
        vt[1]  = '{"sw",      6'b101011, 6'b000000, 1'b1, 4, 0, 1, 1, 0, 3'b010};
        vt[2]  = '{"add",     6'b000000, 6'b100000, 1'b0, 4, 1, 0, 1, 0, 3'b010};
        vt[3]  = '{"sub",     6'b000000, 6'b100010, 1'b0, 4, 1, 0, 1, 0, 3'b110};
        vt[4]  = '{"and",     6'b000000, 6'b100100, 1'b1, 4, 1, 0, 1, 0, 3'b000};
        vt[5]  = '{"or",      6'b000000, 6'b100101, 1'b0, 4, 1, 0, 1, 0, 3'b001};
        vt[6]  = '{"slt",     6'b000000, 6'b101010, 1'b0, 4, 1, 0, 1, 0, 3'b111};
        vt[7]  = '{"rfn_unk", 6'b000000, 6'b000111, 1'b0, 4, 1, 0, 1, 0, 3'b010};
        vt[8]  = '{"beq_z1",  6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2, 0, 3'b110};
        vt[9]  = '{"beq_z0",  6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1, 0, 3'b110};
        vt[10] = '{"addi",    6'b001000, 6'b101010, 1'b0, 4, 1, 0, 1, 0, 3'b010};
        vt[11] = '{"j",       6'b000010, 6'b000000, 1'b0, 3, 0, 0, 2, 0, 3'b010};
        vt[12] = '{"illegal", 6'b111111, 6'b000000, 1'b0, 2, 0, 0, 1, 1, 3'b000};
        vt[13] = '{"ill_zero",6'b010101, 6'b100010, 1'b1, 2, 0, 0, 1, 1, 3'b000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        // Reset state: FETCH values with write enables held low
        #2;
        chk("rst_state", 32'(State), 0);
        chk("rst_pcen", 32'(PCEn), 0);
        chk("rst_irwrite", 32'(IRWrite), 0);
        chk("rst_alusrcb", 32'(ALUSrcB), 1);
        tick;
        chk("rst_hold_state", 32'(State), 0);
        #1 RESET = 1'b0;
        #1 chk("post_rst_pcen", 32'(PCEn), 1);

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].fn, vt[i].z, lat, rw, mw, pe, il, a3);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
            chk({vt[i].name, "_regw"}, 32'(rw), 32'(vt[i].rw));
            chk({vt[i].name, "_memw"}, 32'(mw), 32'(vt[i].mw));
            chk({vt[i].name, "_pcen"}, 32'(pe), 32'(vt[i].pe));
            chk({vt[i].name, "_illegal"}, 32'(il), 32'(vt[i].il));
            if (vt[i].lat >= 3) chk({vt[i].name, "_alu3"}, 32'(a3), 32'(vt[i].a3));
        end

        // Asynchronous reset landing in the middle of a load's MEMRD cycle
        Op = 6'b100011; Funct = '0; Zero = 1'b1;
        tick; tick; tick;
        chk("mid_memrd_state", 32'(State), 3);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_state", 32'(State), 0);
        chk("async_rst_pcen", 32'(PCEn), 0);
        chk("async_rst_irwrite", 32'(IRWrite), 0);
        chk("async_rst_regwrite", 32'(RegWrite), 0);
        tick;
        chk("rst_held_state", 32'(State), 0);
        chk("rst_held_pcen", 32'(PCEn), 0);
        RESET = 1'b0;
        #1 chk("release_irwrite", 32'(IRWrite), 1);
        tick;
        chk("release_decode", 32'(State), 1);
        tick;
        chk("release_memadr", 32'(State), 2);
        tick; tick; tick;
        chk("release_back_fetch", 32'(State), 0);

        // Random instruction stream, cycle-by-cycle against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'($urandom);
                default: op = 6'b111111;
            endcase
            fn = $urandom_range(0, 1) ? fns[$urandom_range(0, 5)] : 6'($urandom);
            seq_of(op, q);
            Op = op; Funct = fn;
            foreach (q[k]) begin
                Zero = 1'($urandom);
                #1;
                chk("rnd_state", 32'(State), 32'(q[k]));
                chk("rnd_outputs", 32'(dut_out()), 32'(ref_out(q[k], op, fn, Zero)));
                tick;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
